// File: rtl/reg_bank_16x16.sv
// reg_bank_16x16: sixteen DATA_W-bit registers with a single write port,
// write accept/reject pulses, and a sequential clear that walks r0..r15
// one register per cycle while busy is high.
module reg_bank_16x16 #(
   parameter int DATA_W = 16,
   parameter int NREG   = 16   // the port list below is fixed at 16 registers
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_en,
   input  logic [4:0]        wr_select,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              clr_start,
   output logic [DATA_W-1:0] r0,
   output logic [DATA_W-1:0] r1,
   output logic [DATA_W-1:0] r2,
   output logic [DATA_W-1:0] r3,
   output logic [DATA_W-1:0] r4,
   output logic [DATA_W-1:0] r5,
   output logic [DATA_W-1:0] r6,
   output logic [DATA_W-1:0] r7,
   output logic [DATA_W-1:0] r8,
   output logic [DATA_W-1:0] r9,
   output logic [DATA_W-1:0] r10,
   output logic [DATA_W-1:0] r11,
   output logic [DATA_W-1:0] r12,
   output logic [DATA_W-1:0] r13,
   output logic [DATA_W-1:0] r14,
   output logic [DATA_W-1:0] r15,
   output logic              wr_ack,
   output logic              wr_err,
   output logic              busy
);

   localparam logic [0:0] IDLE  = 1'b0;
   localparam logic [0:0] CLEAR = 1'b1;

   logic [0:0]        state;
   logic [3:0]        clr_idx;
   logic [DATA_W-1:0] regs [NREG];

   logic              wr_take;    // write request actually considered this edge
   logic              sel_zero;   // accepted no-op target
   logic              sel_legal;  // targets r0..r15
   logic [3:0]        wr_idx;

   // Decode the write request; a clear request in IDLE pre-empts any write,
   // and nothing is written while the clear sequence runs.
   always_comb begin
      wr_take   = (state == IDLE) && wr_en && !clr_start;
      sel_zero  = (wr_select == 5'd0);
      sel_legal = !sel_zero && (wr_select <= 5'd16);
      // 1..16 map to 0..15; 16 wraps 0-1 to 15 in four bits.
      wr_idx    = wr_select[3:0] - 4'd1;
   end

   // Two-state controller: IDLE, or CLEAR walking clr_idx 0..15 then wrapping.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         clr_idx <= 4'd0;
      end else begin
         case (state)
            IDLE: begin
               if (clr_start) begin
                  state   <= CLEAR;
                  clr_idx <= 4'd0;
               end
            end
            CLEAR: begin
               clr_idx <= clr_idx + 4'd1;
               if (clr_idx == 4'd15) begin
                  state <= IDLE;
               end
            end
            default: begin
               state   <= IDLE;
               clr_idx <= 4'd0;
            end
         endcase
      end
   end

   // One-cycle response pulses; mutually exclusive by construction.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ack <= 1'b0;
         wr_err <= 1'b0;
      end else begin
         wr_ack <= wr_take && (sel_zero || sel_legal);
         wr_err <= wr_take && !sel_zero && !sel_legal;
      end
   end

   // Register storage: cleared one per cycle in CLEAR, otherwise loaded by legal writes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREG; i++) begin
            regs[i] <= '0;
         end
      end else if (state == CLEAR) begin
         regs[clr_idx] <= '0;
      end else if (wr_take && sel_legal) begin
         regs[wr_idx] <= wr_data;
      end
   end

   assign busy = (state == CLEAR);

   assign r0  = regs[0];
   assign r1  = regs[1];
   assign r2  = regs[2];
   assign r3  = regs[3];
   assign r4  = regs[4];
   assign r5  = regs[5];
   assign r6  = regs[6];
   assign r7  = regs[7];
   assign r8  = regs[8];
   assign r9  = regs[9];
   assign r10 = regs[10];
   assign r11 = regs[11];
   assign r12 = regs[12];
   assign r13 = regs[13];
   assign r14 = regs[14];
   assign r15 = regs[15];

endmodule

// File: doc/reg_bank_16x16.md
REG_BANK_16X16 -- requirements
Module: reg_bank_16x16

Interface
REQ-001 Parameter: DATA_W, 16, width of every register and of wr_data.
REQ-002 Parameter: NREG, 16, number of registers; fixed at 16, no other value supported.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset; asynchronous, active-low.
REQ-005 wr_en  input  1  write request, sampled each rising edge.
REQ-006 wr_select  input  5  write target; 0 = no target, 1..16 = r0..r15, 17..31 = illegal.
REQ-007 wr_data  input  DATA_W  write data.
REQ-008 clr_start  input  1  request to zero all registers sequentially.
REQ-009 r0..r15  output  DATA_W each  register contents, driven directly from flops; feed the 5-bit-select read mux.
REQ-010 wr_ack  output  1  one-cycle pulse; write request accepted.
REQ-011 wr_err  output  1  one-cycle pulse; write request rejected for illegal wr_select.
REQ-012 busy  output  1  high while the clear sequence runs.

Function
REQ-013 States SHALL be IDLE and CLEAR only; a 4-bit clr_idx SHALL track the clear position.
REQ-014 IDLE, wr_en=1, clr_start=0, wr_select 1..16: register r[wr_select-1] SHALL load wr_data at the edge; wr_ack SHALL be 1 the following cycle.
REQ-015 Written value SHALL appear on the r output in the cycle after the sampling edge (latency 1); no write-through of wr_data.
REQ-016 IDLE, wr_en=1, wr_select=0: no register SHALL change; wr_ack SHALL still pulse (accepted no-op).
REQ-017 IDLE, wr_en=1, wr_select 17..31: no register SHALL change; wr_err SHALL pulse next cycle; wr_ack SHALL stay 0.
REQ-018 wr_ack and wr_err SHALL never be 1 in the same cycle and SHALL each be 1 for exactly one cycle per sampled request.
REQ-019 Back-to-back wr_en on consecutive cycles SHALL each be processed; ack/err pulses SHALL then be contiguous.
REQ-020 Write to the same register on consecutive cycles: last write SHALL win.
REQ-021 IDLE, clr_start=1: next state SHALL be CLEAR, clr_idx=0, busy=1 from next cycle.
REQ-022 clr_start and wr_en both 1 in IDLE: clear SHALL win; the write SHALL be dropped with wr_ack=0 and wr_err=0.
REQ-023 CLEAR: each cycle r[clr_idx] SHALL be set to 0 and clr_idx SHALL increment; sequence SHALL last exactly 16 cycles (r0 first, r15 last).
REQ-024 After r15 is cleared, state SHALL return to IDLE and busy SHALL drop to 0 in the same edge; clr_idx SHALL wrap to 0.
REQ-025 CLEAR: wr_en SHALL be ignored (no write, wr_ack=0, wr_err=0); clr_start SHALL be ignored (no restart).
REQ-026 Registers not yet reached by the clear SHALL keep their values until their cycle.

Reset
REQ-027 rst_n=0 SHALL immediately, independent of clk, force r0..r15=0, wr_ack=0, wr_err=0, busy=0, state=IDLE, clr_idx=0.
REQ-028 Reset asserted mid-CLEAR SHALL abort the sequence; after release, block SHALL be in IDLE with all registers 0.
REQ-029 First edge after rst_n rises SHALL process inputs normally.

Verification
REQ-030 Write wr_select=1 data 16'hA5A5, then wr_select=16 data 16'h1234 -> r0=A5A5, r15=1234 one cycle after each edge; wr_ack pulses twice; others 0.
REQ-031 wr_en=1 wr_select=17 data 16'hFFFF -> wr_err=1 one cycle, wr_ack=0, all registers unchanged.
REQ-032 Load r0..r15 with 16'h0001..16'h0010, pulse clr_start -> busy high 16 cycles; at cycle k r(k-1) becomes 0 and higher registers retain values; all 0 when busy falls.
REQ-033 clr_start and wr_en (wr_select=3, 16'hBEEF) same cycle -> no ack, r2 cleared not written; wr_en during CLEAR -> no ack/err.
REQ-034 Assert rst_n=0 between clock edges during cycle 8 of CLEAR -> outputs 0 immediately; after release busy=0, write wr_select=5 16'h00FF accepted next edge.
REQ-035 wr_en held 1 for 4 cycles, wr_select 2,2,0,20 -> r1 holds last value, ack,ack,ack,err sequence.
